// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: shared fetch-entry type, default reset PC and word-align helper
package core_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/core_fetch_fifo.sv
// core_fetch_fifo: power-of-two instruction buffer with synchronous clear
module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  T                           din_i,
  input  logic                       pop_i,
  output T                           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == CW'(DEPTH);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // pointers and occupancy; clear wipes the buffer regardless of push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  // storage needs no reset: occupancy decides what is visible
  always_ff @(posedge clk)
    if (do_push & ~clear_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/core_fetch.sv
// core_fetch: sequential-PC fetch stage with credit-limited requests, in-order buffering and redirect flush
// Define CORE_FETCH_BYPASS_EN to present a kept response to decode in the same cycle when the buffer is empty.
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_ir,
  input  logic        d_ready,
  output logic        d_flush
);
  localparam int CW = $clog2(DEPTH+1);
  logic          run_q;
  logic [31:0]   pc_q, pc_d, pc_rsp_q, pc_rsp_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic          accept, keep, push, pop, empty, full;
  fetch_entry_t  rsp_entry, head;
  assign d_flush        = redirect_valid;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = run_q & ~redirect_valid & ~full &
                          (({1'b0, count} + {1'b0, out_q}) < (CW+1)'(DEPTH));
  assign accept         = imem_req_valid & imem_req_ready;
  assign keep           = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
  assign rsp_entry      = '{pc: pc_rsp_q, ir: imem_rsp_data};
  assign pop            = ~empty & d_ready;
`ifdef CORE_FETCH_BYPASS_EN
  logic byp;
  assign byp           = empty & keep;
  assign d_valid       = ~empty | byp;
  assign {d_pc, d_ir}  = empty ? rsp_entry : head;
  assign push          = keep & ~(byp & d_ready);
`else
  assign d_valid       = ~empty;
  assign {d_pc, d_ir}  = head;
  assign push          = keep;
`endif
  // next PCs and counters; a redirect re-targets both PCs and owes every still-in-flight response
  always_comb begin
    pc_d     = redirect_valid ? word_align(redirect_pc) : accept ? pc_q + 32'd4 : pc_q;
    pc_rsp_d = redirect_valid ? word_align(redirect_pc) : keep ? pc_rsp_q + 32'd4 : pc_rsp_q;
    out_d    = out_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d   = redirect_valid ? out_d :
               (imem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  // run_q holds requests off until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      pc_rsp_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      run_q    <= 1'b1;
      pc_q     <= pc_d;
      pc_rsp_q <= pc_rsp_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  core_fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (redirect_valid),
    .push_i  (push),
    .din_i   (rsp_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );
endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: random/directed fetch traffic against an epoch-tagged reference of the fetch stream
module tb_core_fetch;
  import core_fetch_pkg::*;
  localparam int DEPTH = 2;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, d_pc, d_ir;
  logic        redirect_valid, d_valid, d_ready, d_flush;

  core_fetch #(.RESET_PC(32'h100), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .d_valid(d_valid), .d_pc(d_pc), .d_ir(d_ir), .d_ready(d_ready), .d_flush(d_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ep;
    logic [31:0] a;
  } req_t;

  req_t        pend[$];
  int unsigned epoch = 0;
  int          fifo_n = 0;
  logic [31:0] exp_pc = 32'h100, exp_addr = 32'h100, last_acc = '0;
  bit          run = 1'b0, saw_wrap = 1'b0;
  int          rsp_pct = 100, rdy_pct = 100, drdy_pct = 100;
  int          errors = 0, checks = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive memory/decode/redirect, check outputs against the model, advance the model
  task automatic step(input bit redir = 1'b0, input logic [31:0] tgt = '0);
    bit rsp, keep, acc, exp_dv, byp_use;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    d_ready        = ($urandom_range(99) < drdy_pct);
    rsp            = (pend.size() != 0) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(pend[0].a) : $urandom;
    keep           = rsp && pend[0].ep == epoch && !redir;
`ifdef CORE_FETCH_BYPASS_EN
    exp_dv  = fifo_n > 0 || keep;
    byp_use = keep && fifo_n == 0 && d_ready;
`else
    exp_dv  = fifo_n > 0;
    byp_use = 1'b0;
`endif
    #1;
    chk("d_flush", {31'b0, d_flush}, {31'b0, redir});
    chk("req_valid", {31'b0, imem_req_valid},
        {31'b0, run && !redir && (fifo_n + pend.size() < DEPTH)});
    chk("d_valid", {31'b0, d_valid}, {31'b0, exp_dv});
    if (exp_dv && !redir) begin
      chk("d_pc", d_pc, exp_pc);
      chk("d_ir", d_ir, memf(exp_pc));
    end
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_addr);
      if (imem_req_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      last_acc = imem_req_addr;
    end
    if (rsp) void'(pend.pop_front());
    if (acc) begin
      pend.push_back('{epoch, imem_req_addr});
      exp_addr += 32'd4;
    end
    if (redir) begin
      fifo_n   = 0;
      epoch++;
      exp_pc   = {tgt[31:2], 2'b00};
      exp_addr = exp_pc;
    end else begin
      if (exp_dv && d_ready) exp_pc += 32'd4;
      fifo_n = fifo_n + ((keep && !byp_use) ? 1 : 0) - ((fifo_n > 0 && d_ready) ? 1 : 0);
    end
    @(posedge clk);
    run = rst_n;
    @(negedge clk);
  endtask

  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    rst_n = 1'b1;
    // streaming from reset PC
    repeat (12) step();
    // decode stalled: credit limit stops requests, then a pop releases one
    drdy_pct = 0;
    repeat (10) step();
    drdy_pct = 100;
    repeat (4) step();
    // redirect with requests outstanding, misaligned target
    rsp_pct = 0;
    repeat (4) step();
    step(1'b1, 32'h2003);
    rsp_pct = 100;
    repeat (8) step();
    // redirect coinciding with a response and a pop
    rsp_pct = 0; drdy_pct = 0;
    repeat (4) step();
    rsp_pct = 100;
    step();
    drdy_pct = 100;
    step(1'b1, 32'h3000);
    repeat (6) step();
    // redirect while responses are still owed, then back-to-back redirects
    rsp_pct = 0;
    repeat (3) step();
    step(1'b1, 32'h4000);
    rsp_pct = 100;
    step();
    step(1'b1, 32'h5000);
    step(1'b1, 32'h6008);
    repeat (8) step();
    // PC wrap with a randomly stalling memory
    rdy_pct = 50; rsp_pct = 70; drdy_pct = 70;
    step(1'b1, 32'hFFFF_FFF4);
    repeat (40) step();
    chk("pc_wrap_seen", {31'b0, saw_wrap}, 32'h1);
    // random soak
    for (int i = 0; i < 600; i++) begin
      rdy_pct  = $urandom_range(30, 100);
      rsp_pct  = $urandom_range(30, 100);
      drdy_pct = $urandom_range(0, 100);
      if ($urandom_range(99) < 6)
        step(1'b1, $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15))));
      else
        step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
